yags_dir_cache: RTL and testbench

- Parametrised N-way set-associative YAGS direction cache; successor to the single-table fully-searched taken array.
- One instance serves as the taken cache and a second as the not-taken cache, selected by parameter BIAS_TAKEN.
- Fetch-stage lookup is combinational from PC^GHR; the EX-stage update port applies counter training, allocation and true-LRU replacement.
- Entries are cleared by a per-set sweep FSM after reset and on flush.

---
 rtl/yags_pkg.sv | 52 +++++
 rtl/yags_age_lru.sv | 77 +++++++
 rtl/yags_dir_cache.sv | 182 ++++++++++++++++++
 tb/tb_yags_dir_cache.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/yags_pkg.sv
// Shared types and counter helpers for the YAGS direction caches.
// Counter values are generic in CTR_W; the named 2-bit states cover the default.
package yags_pkg;

  localparam int CTR_MAX_W = 8;
  localparam int DC_TAG_W  = 8;
  localparam int DC_CTR_W  = 2;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef enum logic {
    INIT,
    RUN
  } dc_state_e;

  typedef struct packed {
    logic                valid;
    logic [DC_TAG_W-1:0] tag;
    logic [DC_CTR_W-1:0] ctr;
  } dc_entry_t;

  function automatic logic [CTR_MAX_W-1:0] ctr_wt(
    input int unsigned w
  );
    if (w == 2) return CTR_MAX_W'(WT);
    return CTR_MAX_W'(1) << (w - 1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_wnt(
    input int unsigned w
  );
    if (w == 2) return CTR_MAX_W'(WNT);
    return ctr_wt(w) - CTR_MAX_W'(1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_update(
    input logic [CTR_MAX_W-1:0] ctr,
    input logic                 taken,
    input int unsigned          w = 2
  );
    logic [CTR_MAX_W-1:0] mx;
    if (w == 2) mx = CTR_MAX_W'(ST);
    else mx = (CTR_MAX_W'(1) << w) - CTR_MAX_W'(1);
    if (taken) return (ctr >= mx) ? mx : ctr + CTR_MAX_W'(1);
    if (ctr == CTR_MAX_W'(SNT)) return ctr;
    return ctr - CTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/yags_age_lru.sv
// True-LRU age storage for every set: one touch/clear port and a victim
// picker, both addressed by set index.
module yags_age_lru #(
  parameter int SETS  = 64,
  parameter int IDX_W = 6,
  parameter int WAYS  = 4,
  parameter int WAY_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic             touch_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WAY_W-1:0] way_i,
  input  logic [WAYS-1:0]  valid_i,
  output logic [WAY_W-1:0] victim_o
);

  logic [WAY_W-1:0] age_q   [SETS][WAYS];
  logic [WAY_W-1:0] age_cur [WAYS];
  logic [WAY_W-1:0] age_d   [WAYS];
  logic [WAY_W-1:0] vic;
  logic             inv;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      age_cur[w] = age_q[idx_i][w];
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == way_i)
        age_d[w] = '0;
      else if (age_cur[w] < age_cur[way_i])
        age_d[w] = age_cur[w] + 1'b1;
      else
        age_d[w] = age_cur[w];
    end
  end

  // Empty ways are filled lowest-first before anything is evicted.
  always_comb begin
    vic = '0;
    inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        vic = WAY_W'(w);
        inv = 1'b1;
      end
    end
    if (!inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_cur[w] == WAY_W'(WAYS - 1))
          vic = WAY_W'(w);
      end
    end
  end

  assign victim_o = vic;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else if (clr_i) begin
      for (int w = 0; w < WAYS; w++)
        age_q[clr_idx_i][w] <= WAY_W'(w);
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++)
        age_q[idx_i][w] <= age_d[w];
    end
  end

endmodule

// File: rtl/yags_dir_cache.sv
// N-way YAGS direction cache (taken or not-taken by BIAS_TAKEN).
// Define YAGS_DC_BYPASS_EN to forward same-cycle updates into lookup.
module yags_dir_cache
  import yags_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int GHR_W      = 6,
  parameter int IDX_W      = 6,
  parameter int WAYS       = 4,
  parameter int TAG_W      = 8,
  parameter int CTR_W      = 2,
  parameter int BIAS_TAKEN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  output logic                    ready,
  input  logic                    lu_req,
  input  logic [PC_W-1:0]         lu_pc,
  input  logic [GHR_W-1:0]        lu_ghr,
  output logic [IDX_W-1:0]        lu_index,
  output logic                    lu_hit,
  output logic [$clog2(WAYS)-1:0] lu_way,
  output logic                    lu_pred,
  input  logic                    upd_valid,
  input  logic [PC_W-1:0]         upd_pc,
  input  logic [IDX_W-1:0]        upd_index,
  input  logic [$clog2(WAYS)-1:0] upd_way,
  input  logic                    upd_hit,
  input  logic                    upd_choice,
  input  logic                    upd_taken
);

  localparam int SETS  = 2 ** IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_wt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_wnt(CTR_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  dc_state_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             clr;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [CTR_W-1:0] ctr_q   [SETS][WAYS];

  logic [TAG_W-1:0] upd_tag;
  logic             conf_hit;
  logic             alloc_ok;
  logic             wr_en;
  logic [WAY_W-1:0] wr_way;
  logic [WAY_W-1:0] victim;
  entry_t           wr_ent;

  entry_t           rd [WAYS];
  logic             hit_any;
  logic [WAY_W-1:0] hit_w;
  logic             unused_ok;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr     = 1'b0;
    unique case (state_q)
      INIT: begin
        clr   = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (flush)
          ptr_d = '0;
        else if (ptr_q == IDX_W'(SETS - 1))
          state_d = RUN;
      end
      RUN: begin
        if (flush) begin
          state_d = INIT;
          ptr_d   = '0;
        end
      end
    endcase
  end

  assign ready = (state_q == RUN);

  assign upd_tag = upd_pc[TAG_W-1:0];

  // A carried hit is only trusted if the way still holds that branch.
  always_comb begin
    conf_hit = upd_hit
      && valid_q[upd_index][upd_way]
      && (tag_q[upd_index][upd_way] == upd_tag);
    if (BIAS_TAKEN != 0)
      alloc_ok = !upd_choice && upd_taken;
    else
      alloc_ok = upd_choice && !upd_taken;
    wr_en  = ready && upd_valid && (conf_hit || alloc_ok);
    wr_way = conf_hit ? upd_way : victim;
    wr_ent.valid = 1'b1;
    wr_ent.tag   = upd_tag;
    if (conf_hit)
      wr_ent.ctr = CTR_W'(sat_update(
        CTR_MAX_W'(ctr_q[upd_index][upd_way]),
        upd_taken, CTR_W));
    else
      wr_ent.ctr = upd_taken ? CTR_WT : CTR_WNT;
  end

  yags_age_lru #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_lru (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .clr_idx_i (ptr_q),
    .touch_i   (wr_en),
    .idx_i     (upd_index),
    .way_i     (wr_way),
    .valid_i   (valid_q[upd_index]),
    .victim_o  (victim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      for (int s = 0; s < SETS; s++)
        valid_q[s] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (clr)
        valid_q[ptr_q] <= '0;
      else if (wr_en)
        valid_q[upd_index][wr_way] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[upd_index][wr_way] <= wr_ent.tag;
      ctr_q[upd_index][wr_way] <= wr_ent.ctr;
    end
  end

  assign lu_index = lu_pc[IDX_W-1:0] ^ lu_ghr[IDX_W-1:0];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      rd[w] = {valid_q[lu_index][w],
               tag_q[lu_index][w],
               ctr_q[lu_index][w]};
    end
`ifdef YAGS_DC_BYPASS_EN
    if (wr_en && (upd_index == lu_index))
      rd[wr_way] = wr_ent;
`endif
    hit_any = 1'b0;
    hit_w   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd[w].valid && (rd[w].tag == lu_pc[TAG_W-1:0])) begin
        hit_any = 1'b1;
        hit_w   = WAY_W'(w);
      end
    end
  end

  assign lu_hit  = ready && lu_req && hit_any;
  assign lu_way  = lu_hit ? hit_w : '0;
  assign lu_pred = lu_hit && rd[hit_w].ctr[CTR_W-1];

  assign unused_ok = ^{lu_pc, upd_pc, lu_ghr};

endmodule

// File: tb/tb_yags_dir_cache.sv
// Directed bench for yags_dir_cache (taken cache, default geometry).
// Lookup expectations flow through a scoreboard queue.
module tb_yags_dir_cache;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       ready;
  logic       lu_req;
  logic [9:0] lu_pc;
  logic [5:0] lu_ghr;
  logic [5:0] lu_index;
  logic       lu_hit;
  logic [1:0] lu_way;
  logic       lu_pred;
  logic       upd_valid;
  logic [9:0] upd_pc;
  logic [5:0] upd_index;
  logic [1:0] upd_way;
  logic       upd_hit;
  logic       upd_choice;
  logic       upd_taken;

  int tests;
  int fails;
  int m_ctr;

  typedef struct {
    string      name;
    logic [3:0] exp;
  } sb_t;

  sb_t sbq[$];

  yags_dir_cache dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .ready      (ready),
    .lu_req     (lu_req),
    .lu_pc      (lu_pc),
    .lu_ghr     (lu_ghr),
    .lu_index   (lu_index),
    .lu_hit     (lu_hit),
    .lu_way     (lu_way),
    .lu_pred    (lu_pred),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_index  (upd_index),
    .upd_way    (upd_way),
    .upd_hit    (upd_hit),
    .upd_choice (upd_choice),
    .upd_taken  (upd_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic expect_lu(input string name, input logic hit,
                           input logic pred, input logic [1:0] way);
    sb_t e;
    e.name = name;
    e.exp  = {hit, pred, way};
    sbq.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.name, {4'b0, lu_hit, lu_pred, lu_way}, {4'b0, e.exp});
    end
  endtask

  task automatic lookup(input logic [9:0] pc, input logic [5:0] idx,
                        input logic hit, input logic pred,
                        input logic [1:0] way, input string name);
    @(negedge clk);
    lu_req = 1'b1;
    lu_pc  = pc;
    lu_ghr = pc[5:0] ^ idx;
    expect_lu(name, hit, pred, way);
    #1;
    drain();
  endtask

  task automatic update(input logic [9:0] pc, input logic [5:0] idx,
                        input logic [1:0] way, input logic hit,
                        input logic choice, input logic taken);
    @(negedge clk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_index  = idx;
    upd_way    = way;
    upd_hit    = hit;
    upd_choice = choice;
    upd_taken  = taken;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  // k counts negedges since the sweep was triggered.
  task automatic sweep(input int first, input int last,
                       input int done, input string name);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      flush = 1'b0;
      #1;
      check({name, " ready"}, 8'(ready), 8'(k == done));
      expect_lu({name, " lu"}, 1'b0, 1'b0, 2'd0);
      drain();
    end
  endtask

  logic seq [8];

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    flush = 1'b0;
    lu_req = 1'b1;
    lu_pc = 10'h2A5;
    lu_ghr = 6'h36;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_index = '0;
    upd_way = '0;
    upd_hit = 1'b0;
    upd_choice = 1'b0;
    upd_taken = 1'b0;

    #2;
    check("rst ready", 8'(ready), 8'd0);
    check("lu_index", 8'(lu_index), 8'h13);
    expect_lu("rst lu", 1'b0, 1'b0, 2'd0);
    drain();

    @(negedge clk);
    rst = 1'b1;
    sweep(1, 64, 64, "init");

    update(10'h2A5, 6'h13, 2'd0, 1'b0, 1'b0, 1'b1);
    m_ctr = 2;
    lookup(10'h2A5, 6'h13, 1'b1, 1'b1, 2'd0, "alloc");
    lookup(10'h2A5, 6'h14, 1'b0, 1'b0, 2'd0, "alloc other set");

    seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      update(10'h2A5, 6'h13, 2'd0, 1'b1, 1'b0, seq[i]);
      if (seq[i]) m_ctr = (m_ctr == 3) ? 3 : m_ctr + 1;
      else m_ctr = (m_ctr == 0) ? 0 : m_ctr - 1;
      lookup(10'h2A5, 6'h13, 1'b1, m_ctr >= 2, 2'd0,
             $sformatf("train%0d", i));
    end

    update(10'h111, 6'h13, 2'd0, 1'b0, 1'b1, 1'b1);
    update(10'h122, 6'h13, 2'd0, 1'b0, 1'b0, 1'b0);
    lookup(10'h111, 6'h13, 1'b0, 1'b0, 2'd0, "noalloc c1t1");
    lookup(10'h122, 6'h13, 1'b0, 1'b0, 2'd0, "noalloc c0t0");

    update(10'h0A1, 6'h05, 2'd0, 1'b0, 1'b0, 1'b1);
    update(10'h0B2, 6'h05, 2'd0, 1'b0, 1'b0, 1'b1);
    update(10'h0C3, 6'h05, 2'd0, 1'b0, 1'b0, 1'b1);
    update(10'h0D4, 6'h05, 2'd0, 1'b0, 1'b0, 1'b1);
    lookup(10'h0A1, 6'h05, 1'b1, 1'b1, 2'd0, "set5 A");
    lookup(10'h0B2, 6'h05, 1'b1, 1'b1, 2'd1, "set5 B");
    lookup(10'h0C3, 6'h05, 1'b1, 1'b1, 2'd2, "set5 C");
    lookup(10'h0D4, 6'h05, 1'b1, 1'b1, 2'd3, "set5 D");
    update(10'h0B2, 6'h05, 2'd1, 1'b1, 1'b0, 1'b1);
    update(10'h0E5, 6'h05, 2'd0, 1'b0, 1'b0, 1'b1);
    lookup(10'h0A1, 6'h05, 1'b0, 1'b0, 2'd0, "evict A");
    lookup(10'h0B2, 6'h05, 1'b1, 1'b1, 2'd1, "keep B");
    lookup(10'h0C3, 6'h05, 1'b1, 1'b1, 2'd2, "keep C");
    lookup(10'h0D4, 6'h05, 1'b1, 1'b1, 2'd3, "keep D");
    lookup(10'h0E5, 6'h05, 1'b1, 1'b1, 2'd0, "new E");

    update(10'h0A1, 6'h05, 2'd0, 1'b1, 1'b0, 1'b0);
    lookup(10'h0E5, 6'h05, 1'b1, 1'b1, 2'd0, "stale E ctr");
    lookup(10'h0A1, 6'h05, 1'b0, 1'b0, 2'd0, "stale A miss");

    update(10'h0F6, 6'h05, 2'd0, 1'b0, 1'b0, 1'b1);
    lookup(10'h0F6, 6'h05, 1'b1, 1'b1, 2'd2, "lru F");
    lookup(10'h0C3, 6'h05, 1'b0, 1'b0, 2'd0, "lru C gone");
    lookup(10'h0D4, 6'h05, 1'b1, 1'b1, 2'd3, "lru D");

    @(negedge clk);
    upd_valid = 1'b1;
    upd_pc = 10'h3C7;
    upd_index = 6'h2A;
    upd_way = 2'd0;
    upd_hit = 1'b0;
    upd_choice = 1'b0;
    upd_taken = 1'b1;
    lu_pc = 10'h3C7;
    lu_ghr = 6'h07 ^ 6'h2A;
    expect_lu("same cyc pre", 1'b0, 1'b0, 2'd0);
    #1;
    drain();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    expect_lu("same cyc post", 1'b1, 1'b1, 2'd0);
    drain();

    @(negedge clk);
    flush = 1'b1;
    lu_pc = 10'h2A5;
    lu_ghr = 6'h36;
    sweep(1, 65, 65, "flush");
    lookup(10'h2A5, 6'h13, 1'b0, 1'b0, 2'd0, "flushed 2A5");
    lookup(10'h0B2, 6'h05, 1'b0, 1'b0, 2'd0, "flushed B");
    lookup(10'h3C7, 6'h2A, 1'b0, 1'b0, 2'd0, "flushed 3C7");

    @(negedge clk);
    flush = 1'b1;
    sweep(1, 10, 65, "pre restart");
    @(negedge clk);
    flush = 1'b1;
    sweep(1, 65, 65, "restart");

    @(negedge clk);
    flush = 1'b1;
    sweep(1, 6, 65, "drop");
    update(10'h015, 6'h00, 2'd0, 1'b0, 1'b0, 1'b1);
    sweep(8, 65, 65, "drop tail");
    lookup(10'h015, 6'h00, 1'b0, 1'b0, 2'd0, "dropped upd");

    @(negedge clk);
    flush = 1'b1;
    sweep(1, 20, 65, "mid");
    rst = 1'b0;
    #1;
    check("rst mid ready", 8'(ready), 8'd0);
    @(negedge clk);
    rst = 1'b1;
    sweep(1, 64, 64, "rst mid");

    update(10'h2A5, 6'h13, 2'd0, 1'b0, 1'b0, 1'b1);
    lookup(10'h2A5, 6'h13, 1'b1, 1'b1, 2'd0, "realloc");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
